// File: rtl/key_edge_pio.sv
// Avalon-MM push-button PIO: synchronizes and debounces active-low keys,
// latches press edges and raises a masked, registered level interrupt.
module key_edge_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             avs_chipselect,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] keys_export,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [CNT_W-1:0] cnt_r     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] db_r;
    logic [WIDTH-1:0] db_nxt_s;
    logic [WIDTH-1:0] press_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edge_r;
    logic [WIDTH-1:0] edge_nxt_s;
    logic [WIDTH-1:0] w1c_s;
    logic             mask_we_s;
    logic             edge_we_s;
    logic             rd_en_s;
    logic [31:0]      rd_mux_s;
    logic             irq_nxt_s;
    logic             irq_r;

    // Two-flop synchronizer; reset to released (high) so no false press at startup.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_r <= {WIDTH{1'b1}};
            sync2_r <= {WIDTH{1'b1}};
        end else begin
            sync1_r <= keys_export;
            sync2_r <= sync1_r;
        end
    end

    // Per-key stability counter; state flips only after an unbroken run of disagreement.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
            db_nxt_s[i]  = db_r[i];
            if ((~sync2_r[i]) != db_r[i]) begin
                if (cnt_r[i] == CNT_LAST) begin
                    db_nxt_s[i]  = ~sync2_r[i];
                    cnt_nxt_s[i] = CNT_ZERO;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else begin
                cnt_nxt_s[i] = CNT_ZERO;
            end
        end
        press_s = db_nxt_s & ~db_r;
    end

    // Debounce counters and debounced pressed state.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            db_r <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            db_r <= db_nxt_s;
        end
    end

    // Bus decode; a press landing with a clear on the same bit keeps the bit set.
    always_comb begin
        mask_we_s = avs_chipselect & avs_write & (avs_address == ADDR_MASK);
        edge_we_s = avs_chipselect & avs_write & (avs_address == ADDR_EDGE);
        rd_en_s   = avs_chipselect & avs_read;
        if (edge_we_s) begin
            w1c_s = avs_writedata[WIDTH-1:0];
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
        edge_nxt_s = (edge_r & ~w1c_s) | press_s;
        irq_nxt_s  = |(edge_r & mask_r);
    end

    // Read-data selection; unimplemented upper bits stay zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs_address)
            ADDR_DATA: rd_mux_s[WIDTH-1:0] = db_r;
            ADDR_MASK: rd_mux_s[WIDTH-1:0] = mask_r;
            ADDR_EDGE: rd_mux_s[WIDTH-1:0] = edge_r;
            ADDR_RAW:  rd_mux_s[WIDTH-1:0] = sync2_r;
            default:   rd_mux_s = 32'd0;
        endcase
    end

    // Control/status registers and the registered interrupt.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mask_r <= {WIDTH{1'b0}};
            edge_r <= {WIDTH{1'b0}};
            irq_r  <= 1'b0;
        end else begin
            if (mask_we_s) begin
                mask_r <= avs_writedata[WIDTH-1:0];
            end else begin
                mask_r <= mask_r;
            end
            edge_r <= edge_nxt_s;
            irq_r  <= irq_nxt_s;
        end
    end

    // Fixed one-cycle read latency; the bus sees a held value between reads.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= 32'd0;
        end else if (rd_en_s) begin
            avs_readdata <= rd_mux_s;
        end else begin
            avs_readdata <= avs_readdata;
        end
    end

    assign irq = irq_r;

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata_s;
            assign unused_wdata_s = ^avs_writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: doc/key_edge_pio.md
KEY_EDGE_PIO -- requirements
Module: key_edge_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of key inputs (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, cycles of stable input before acceptance (1 ms at 50 MHz; minimum 2).
REQ-003 SHALL have port clk_clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset_reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port avs_chipselect  input  1  Avalon-MM slave select.
REQ-006 SHALL have port avs_address  input  2  word address.
REQ-007 SHALL have port avs_read  input  1  read strobe.
REQ-008 SHALL have port avs_write  input  1  write strobe.
REQ-009 SHALL have port avs_writedata  input  32  write data.
REQ-010 SHALL have port avs_readdata  output  32  registered read data.
REQ-011 SHALL have port keys_export  input  WIDTH  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-012 SHALL have port irq  output  1  level interrupt to the Nios II, active-high.

Function
REQ-013 Each key bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per bit: when synced value differs from debounced state, a counter increments each cycle; when synced equals debounced state, counter clears to 0.
REQ-015 Debounced state (pressed = 1, i.e. inverted input) SHALL update in the cycle the counter reaches DEBOUNCE_CYCLES-1, counter clearing to 0 at the same time.
REQ-016 A debounced 0->1 transition (press) SHALL set the corresponding EDGECAPTURE bit on the same clock edge that the debounced state updates; releases set nothing.
REQ-017 Register map (word address): 0 DATA (RO, debounced pressed state); 1 IRQMASK (RW); 2 EDGECAPTURE (RO, write-1-to-clear); 3 RAW (RO, synchronized raw levels, uninverted).
REQ-018 Read: avs_chipselect & avs_read in cycle N SHALL drive avs_readdata with the addressed value in cycle N+1 (fixed latency 1, no waitrequest); avs_readdata holds its value otherwise.
REQ-019 Bits [31:WIDTH] of all read data SHALL be 0; writes to those bits and to addresses 0 and 3 SHALL be ignored.
REQ-020 Write to IRQMASK SHALL take effect on the following edge; write to EDGECAPTURE clears bits where avs_writedata is 1.
REQ-021 New press edge and W1C on the same bit in the same cycle: bit SHALL end set (set wins).
REQ-022 irq SHALL be registered: irq = OR(EDGECAPTURE & IRQMASK) of the previous cycle, i.e. asserts 1 cycle after the enabling bit/mask is set and deasserts 1 cycle after clear.
REQ-023 Read of EDGECAPTURE SHALL not clear it.
REQ-024 Counter width SHALL be sufficient for DEBOUNCE_CYCLES-1 with no wrap; bounce shorter than DEBOUNCE_CYCLES SHALL never change debounced state.

Reset
REQ-025 While reset_reset_n is low: synchronizer flops = all 1 (released), counters = 0, DATA = 0, IRQMASK = 0, EDGECAPTURE = 0, avs_readdata = 0, irq = 0.
REQ-026 Reset asserted mid-debounce or with irq high SHALL immediately return all state to REQ-025 values; a key held through reset release SHALL be reported as a press edge after 2 + DEBOUNCE_CYCLES cycles.

Verification (DEBOUNCE_CYCLES = 4, WIDTH = 4)
REQ-027 Press key0 (keys_export 4'b1110) held -> DATA reads 0x1 and EDGECAPTURE 0x1 after 2 sync + 4 cycles; irq stays 0 (mask 0).
REQ-028 Key1 toggles every 2 cycles for 40 cycles then released -> DATA and EDGECAPTURE remain 0x0.
REQ-029 Write IRQMASK=0x4, press key2 -> irq rises 1 cycle after EDGECAPTURE[2] sets; write 0x4 to address 2 -> irq low 2 cycles after the write.
REQ-030 W1C of bit 0 in the same cycle key0 press edge registers -> EDGECAPTURE[0] = 1 afterward.
REQ-031 Read address 1 after writing 0xFFFFFFFF -> readdata 0x0000000F exactly 1 cycle after read strobe; read address 3 with key3 pressed -> 0x7.
REQ-032 Assert reset_reset_n low while irq = 1 and a debounce is half complete -> irq, avs_readdata, all registers 0 asynchronously; key still held after release -> EDGECAPTURE[n] = 1 after 6 cycles.
